// File: rtl/e203_irq_stress_gen.sv
// Interrupt stress generator and end-of-test monitor for the E203 subsystem.
// Per-channel LFSR-timed IRQ FSMs, commit/dispatch counters and a sticky done flag.
module e203_irq_stress_gen #(
    parameter int NUM_CH   = 3,
    parameter int PC_W     = 32,
    parameter int LFSR_W   = 16,
    parameter int GAP_W    = 10,
    parameter int DONE_CNT = 8,
    parameter int STOP_CNT = 32
) (
    input  logic                   hfclk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_CH-1:0]      ch_en,
    input  logic [LFSR_W-1:0]      seed,
    input  logic [PC_W-1:0]        arm_pc,
    input  logic [PC_W-1:0]        tohost_pc,
    input  logic [NUM_CH*PC_W-1:0] ack_pc,
    input  logic                   cmt_valid,
    input  logic [PC_W-1:0]        cmt_pc,
    input  logic                   i_valid,
    input  logic                   i_ready,
    output logic [NUM_CH-1:0]      irq_o,
    output logic [31:0]            cycle_cnt,
    output logic [31:0]            instr_cnt,
    output logic [31:0]            tohost_cnt,
    output logic [31:0]            end_cycle,
    output logic                   done_o
);

    localparam int CW = GAP_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ASSERT = 2'd2,
        ST_DONE   = 2'd3
    } ch_state_t;

    // Galois feedback masks for maximal-length sequences.
    function automatic logic [LFSR_W-1:0] lfsr_taps();
        logic [31:0] t;
        case (LFSR_W)
            32'd4:   t = 32'h0000_000C;
            32'd5:   t = 32'h0000_0014;
            32'd6:   t = 32'h0000_0030;
            32'd7:   t = 32'h0000_0060;
            32'd8:   t = 32'h0000_00B8;
            32'd10:  t = 32'h0000_0240;
            32'd12:  t = 32'h0000_0E08;
            32'd16:  t = 32'h0000_B400;
            32'd24:  t = 32'h00E1_0000;
            32'd32:  t = 32'h8020_0003;
            default: t = 32'h0000_B400;
        endcase
        return t[LFSR_W-1:0];
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? lfsr_taps() : {LFSR_W{1'b0}});
    endfunction

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] v);
        return (v == {LFSR_W{1'b0}}) ? {{(LFSR_W-1){1'b0}}, 1'b1} : v;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic        arm_hit_s;
    logic        th_hit_s;
    logic        stop_s;
    logic        armed_s;
    logic        armed_r;
    logic        seeded_r;
    logic [31:0] cycle_cnt_r;
    logic [31:0] instr_cnt_r;
    logic [31:0] tohost_cnt_r;
    logic [31:0] end_cycle_r;
    logic        done_r;

    assign arm_hit_s = cmt_valid & (cmt_pc == arm_pc);
    assign th_hit_s  = cmt_valid & (cmt_pc == tohost_pc);
    assign stop_s    = tohost_cnt_r > 32'(STOP_CNT);
    // The arming commit itself launches the channels so WAIT starts one cycle later.
    assign armed_s   = armed_r | (arm_hit_s & enable);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [LFSR_W-1:0] CH_ID = LFSR_W'(c + 1);

        ch_state_t         state_r;
        logic [CW-1:0]     cnt_r;
        logic              irq_r;
        logic [LFSR_W-1:0] lfsr_r;
        logic [LFSR_W-1:0] lfsr_cur_s;
        logic [LFSR_W-1:0] lfsr_nxt_s;
        logic [CW-1:0]     gap_s;
        logic              ack_hit_s;

        assign ack_hit_s  = cmt_valid & (cmt_pc == ack_pc[c*PC_W +: PC_W]);
        assign lfsr_cur_s = seeded_r ? lfsr_r : seed_fix(seed ^ CH_ID);
        assign lfsr_nxt_s = lfsr_step(lfsr_cur_s);
        assign gap_s      = {1'b0, lfsr_cur_s[GAP_W-1:0]} + {{GAP_W{1'b0}}, 1'b1};
        assign irq_o[c]   = irq_r;

        // Channel FSM: gap countdown, IRQ assertion and retirement on handler ack.
        always_ff @(posedge hfclk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= ST_IDLE;
                cnt_r   <= {CW{1'b0}};
                irq_r   <= 1'b0;
                lfsr_r  <= {LFSR_W{1'b0}};
            end else begin
                lfsr_r <= lfsr_cur_s;
                if (!enable) begin
                    state_r <= ST_IDLE;
                    irq_r   <= 1'b0;
                end else begin
                    case (state_r)
                        ST_IDLE: begin
                            irq_r <= 1'b0;
                            if (armed_s && ch_en[c]) begin
                                state_r <= ST_WAIT;
                                cnt_r   <= gap_s;
                                lfsr_r  <= lfsr_nxt_s;
                            end
                        end
                        ST_WAIT: begin
                            if (cnt_r == CW'(1)) begin
                                state_r <= ST_ASSERT;
                                irq_r   <= 1'b1;
                            end else begin
                                cnt_r <= cnt_r - CW'(1);
                            end
                        end
                        ST_ASSERT: begin
                            if (ack_hit_s) begin
                                irq_r <= 1'b0;
                                if (stop_s) begin
                                    state_r <= ST_DONE;
                                end else begin
                                    state_r <= ST_WAIT;
                                    cnt_r   <= gap_s;
                                    lfsr_r  <= lfsr_nxt_s;
                                end
                            end
                        end
                        ST_DONE: begin
                            irq_r <= 1'b0;
                        end
                        default: begin
                            state_r <= ST_IDLE;
                            irq_r   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Arming latch and one-shot seed load after reset release.
    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r  <= 1'b0;
            seeded_r <= 1'b0;
        end else begin
            seeded_r <= 1'b1;
            if (arm_hit_s && enable) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Saturating test counters and sticky done flag.
    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_r  <= 32'd0;
            instr_cnt_r  <= 32'd0;
            tohost_cnt_r <= 32'd0;
            end_cycle_r  <= 32'd0;
            done_r       <= 1'b0;
        end else begin
            cycle_cnt_r <= sat_inc(cycle_cnt_r);
            if (th_hit_s) begin
                tohost_cnt_r <= sat_inc(tohost_cnt_r);
            end
            if (th_hit_s && (tohost_cnt_r == 32'd0)) begin
                end_cycle_r <= cycle_cnt_r;
            end
            if (i_valid && i_ready && (tohost_cnt_r == 32'd0)) begin
                instr_cnt_r <= sat_inc(instr_cnt_r);
            end
            if ((tohost_cnt_r >= 32'(DONE_CNT)) && (irq_o == {NUM_CH{1'b0}})) begin
                done_r <= 1'b1;
            end
        end
    end

    assign cycle_cnt  = cycle_cnt_r;
    assign instr_cnt  = instr_cnt_r;
    assign tohost_cnt = tohost_cnt_r;
    assign end_cycle  = end_cycle_r;
    assign done_o     = done_r;

endmodule

// File: tb/tb_e203_irq_stress_gen.sv
// Directed bench for e203_irq_stress_gen; gaps are hand-derived from seed 16'h0001
// (channel seeds 1,3,2 give first gaps 2,4,3; the following gaps are 1,2,2).
module tb_e203_irq_stress_gen;

    localparam logic [31:0] ARM_PC = 32'h0000_0100;
    localparam logic [31:0] TH_PC  = 32'h0000_0200;

    logic        hfclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable;
    logic [2:0]  ch_en;
    logic [15:0] seed;
    logic [31:0] arm_pc;
    logic [31:0] tohost_pc;
    logic [95:0] ack_pc;
    logic        cmt_valid;
    logic [31:0] cmt_pc;
    logic        i_valid;
    logic        i_ready;
    logic [2:0]  irq_o;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
    logic [31:0] tohost_cnt;
    logic [31:0] end_cycle;
    logic        done_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] exp_end;

    e203_irq_stress_gen dut (
        .hfclk      (hfclk),
        .rst_n      (rst_n),
        .enable     (enable),
        .ch_en      (ch_en),
        .seed       (seed),
        .arm_pc     (arm_pc),
        .tohost_pc  (tohost_pc),
        .ack_pc     (ack_pc),
        .cmt_valid  (cmt_valid),
        .cmt_pc     (cmt_pc),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .irq_o      (irq_o),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt),
        .tohost_cnt (tohost_cnt),
        .end_cycle  (end_cycle),
        .done_o     (done_o)
    );

    always #5 hfclk = ~hfclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge hfclk);
        #1;
        if (rst_n) cyc++;
    endtask

    task automatic commit(input logic [31:0] pc);
        cmt_valid = 1'b1;
        cmt_pc    = pc;
        tick();
        cmt_valid = 1'b0;
        cmt_pc    = 32'd0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_irq", {29'd0, irq_o}, 32'd0);
        check("rst_cycle", cycle_cnt, 32'd0);
        check("rst_instr", instr_cnt, 32'd0);
        check("rst_tohost", tohost_cnt, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        @(negedge hfclk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        enable    = 1'b1;
        ch_en     = 3'b111;
        seed      = 16'h0001;
        arm_pc    = ARM_PC;
        tohost_pc = TH_PC;
        ack_pc    = {32'h0000_0308, 32'h0000_0304, 32'h0000_0300};
        cmt_valid = 1'b0;
        cmt_pc    = 32'd0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        #2;
        reset_pulse();
        check("rst_end_cycle", end_cycle, 32'd0);

        repeat (3) tick();
        check("cycle_cnt_3", cycle_cnt, cyc);

        // Stalled dispatch is not counted; 100 handshakes, tohost, 50 more.
        i_valid = 1'b1;
        repeat (5) tick();
        i_ready = 1'b1;
        repeat (100) tick();
        i_valid = 1'b0;
        i_ready = 1'b0;
        exp_end = 32'(cyc);
        commit(TH_PC);
        check("tohost_1", tohost_cnt, 32'd1);
        check("end_cycle_a", end_cycle, exp_end);
        i_valid = 1'b1;
        i_ready = 1'b1;
        repeat (50) tick();
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("instr_cnt_100", instr_cnt, 32'd100);

        // Arm: gaps 2,4,3 for channels 0,1,2.
        commit(ARM_PC);
        check("arm_t0", {29'd0, irq_o}, 32'h0);
        tick();
        check("arm_t1", {29'd0, irq_o}, 32'h0);
        tick();
        check("arm_t2", {29'd0, irq_o}, 32'h1);
        tick();
        check("arm_t3", {29'd0, irq_o}, 32'h5);
        tick();
        check("arm_t4", {29'd0, irq_o}, 32'h7);
        repeat (5) tick();
        check("irq_hold", {29'd0, irq_o}, 32'h7);

        // Ack channel 1: falls next cycle, re-asserts after a gap of 2.
        commit(32'h0000_0304);
        check("ack1_fall", {29'd0, irq_o}, 32'h5);
        tick();
        check("ack1_gap1", {29'd0, irq_o}, 32'h5);
        tick();
        check("ack1_rearm", {29'd0, irq_o}, 32'h7);

        enable = 1'b0;
        tick();
        check("enable_drop", {29'd0, irq_o}, 32'h0);
        enable = 1'b1;
        repeat (6) tick();

        reset_pulse();
        repeat (10) tick();
        check("no_resume_irq", {29'd0, irq_o}, 32'h0);
        check("cycle_cnt_10", cycle_cnt, 32'd10);

        // Channel 0 only: done waits for the ack.
        ch_en = 3'b001;
        commit(ARM_PC);
        tick();
        tick();
        check("b_irq0", {29'd0, irq_o}, 32'h1);
        exp_end   = 32'(cyc);
        cmt_valid = 1'b1;
        cmt_pc    = TH_PC;
        repeat (8) tick();
        cmt_valid = 1'b0;
        check("b_tohost_8", tohost_cnt, 32'd8);
        check("b_end_cycle", end_cycle, exp_end);
        repeat (3) tick();
        check("b_done_held", {31'd0, done_o}, 32'd0);
        commit(32'h0000_0300);
        check("b_ack0_irq", {29'd0, irq_o}, 32'h0);
        check("b_ack0_done", {31'd0, done_o}, 32'd0);
        tick();
        check("b_done_rise", {31'd0, done_o}, 32'd1);
        check("b_irq0_rearm", {29'd0, irq_o}, 32'h1);
        repeat (5) tick();
        check("b_done_sticky", {31'd0, done_o}, 32'd1);

        // Past STOP_CNT every ack retires its channel for good.
        reset_pulse();
        ch_en = 3'b111;
        commit(ARM_PC);
        repeat (4) tick();
        check("c_all_high", {29'd0, irq_o}, 32'h7);
        exp_end   = 32'(cyc);
        cmt_valid = 1'b1;
        cmt_pc    = TH_PC;
        repeat (33) tick();
        cmt_valid = 1'b0;
        check("c_tohost_33", tohost_cnt, 32'd33);
        check("c_end_cycle", end_cycle, exp_end);
        check("c_done_pre", {31'd0, done_o}, 32'd0);
        commit(32'h0000_0300);
        check("c_ack0", {29'd0, irq_o}, 32'h6);
        commit(32'h0000_0304);
        check("c_ack1", {29'd0, irq_o}, 32'h4);
        commit(32'h0000_0308);
        check("c_ack2", {29'd0, irq_o}, 32'h0);
        tick();
        check("c_done", {31'd0, done_o}, 32'd1);
        repeat (20) tick();
        check("c_irq_stays_0", {29'd0, irq_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
